// File: rtl/gpu_cmd_assembler.sv
// gpu_cmd_assembler
// Collects host bytes into 32-bit GPU instruction words (opcode in bits [7:0],
// arguments least significant byte first). Completed words go into a small FIFO,
// and an issue FSM drains that FIFO as single-cycle instruction strobes spaced
// MIN_GAP idle cycles apart.
// A partial word with no new byte for TIMEOUT cycles is discarded and flagged
// on o_error.
// Optional build macro GPU_CMD_OPCODE_FILTER_EN: words whose opcode is 0x00 or
// above 0x07 are dropped at push time and flagged on o_error.
module gpu_cmd_assembler #(
    parameter int DEPTH   = 4,
    parameter int MIN_GAP = 1,
    parameter int TIMEOUT = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_byte,
    input  logic        i_byte_valid,
    output logic        o_byte_ready,
    output logic [31:0] o_instruction,
    output logic        o_instruction_ready,
    output logic        o_fifo_full,
    output logic        o_error
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT);
    localparam int GW = (MIN_GAP < 1) ? 1 : $clog2(MIN_GAP + 1);

    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(MIN_GAP);

    typedef enum logic {
        IDLE,
        GAP
    } state_e;

    // Assembler state
    logic [1:0]    byte_idx_q, byte_idx_d;
    logic [23:0]   lane_q;
    logic [TW-1:0] tmo_q, tmo_d;

    // FIFO state
    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          full_q;
    logic          error_q, error_d;

    // Issue FSM state
    state_e        state_q;
    logic [GW-1:0] gap_q;
    logic [31:0]   instr_q;
    logic          instr_rdy_q;

    // Datapath strobes
    logic          accept;
    logic          last_byte;
    logic          opcode_ok;
    logic          push;
    logic          pop;
    logic          timeout_hit;
    logic [31:0]   word_in;

    // Only the 4th byte of a word can be refused, and only while the FIFO is full.
    assign o_byte_ready = !((count_q == FULL_CNT) && (byte_idx_q == 2'd3));

    // The 4th byte comes straight from the input so the word is pushed on its edge.
    assign word_in = {i_byte, lane_q};

`ifdef GPU_CMD_OPCODE_FILTER_EN
    assign opcode_ok = (lane_q[7:0] != 8'h00) && (lane_q[7:0] <= 8'h07);
`else
    assign opcode_ok = 1'b1;
`endif

    // Next-state logic for byte lane index, timeout counter, FIFO count and error.
    always_comb begin
        accept      = i_byte_valid && o_byte_ready;
        last_byte   = accept && (byte_idx_q == 2'd3);
        push        = last_byte && opcode_ok;
        pop         = (state_q == IDLE) && (count_q != '0);
        // An accepted byte in the expiry cycle wins over the timeout.
        timeout_hit = (byte_idx_q != 2'd0) && !accept && (tmo_q == TMO_LAST);

        byte_idx_d = byte_idx_q;
        if (accept) begin
            byte_idx_d = byte_idx_q + 2'd1;
        end else if (timeout_hit) begin
            byte_idx_d = 2'd0;
        end

        tmo_d = '0;
        if (!accept && (byte_idx_q != 2'd0) && !timeout_hit) begin
            tmo_d = tmo_q + TW'(1);
        end

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + (AW + 1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (AW + 1)'(1);
        end

        error_d = timeout_hit || (last_byte && !opcode_ok);
    end

    // Assembler lanes, timeout counter, FIFO pointers/count and status flags.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            byte_idx_q <= '0;
            lane_q     <= '0;
            tmo_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            byte_idx_q <= byte_idx_d;
            tmo_q      <= tmo_d;
            count_q    <= count_d;
            full_q     <= (count_d == FULL_CNT);
            error_q    <= error_d;

            if (accept) begin
                case (byte_idx_q)
                    2'd0:    lane_q[7:0]   <= i_byte;
                    2'd1:    lane_q[15:8]  <= i_byte;
                    2'd2:    lane_q[23:16] <= i_byte;
                    default: ;
                endcase
            end else if (timeout_hit) begin
                lane_q <= '0;
            end

            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= word_in;
        end
    end

    // Issue FSM: pop the head in IDLE, then hold off in GAP for MIN_GAP cycles.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            gap_q       <= '0;
            instr_q     <= '0;
            instr_rdy_q <= 1'b0;
        end else begin
            instr_q     <= '0;
            instr_rdy_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        instr_q     <= mem_q[rd_ptr_q];
                        instr_rdy_q <= 1'b1;
                        if (MIN_GAP != 0) begin
                            state_q <= GAP;
                            gap_q   <= GAP_LOAD;
                        end
                    end
                end
                GAP: begin
                    if (gap_q <= GW'(1)) begin
                        state_q <= IDLE;
                        gap_q   <= '0;
                    end else begin
                        gap_q <= gap_q - GW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_instruction       = instr_q;
    assign o_instruction_ready = instr_rdy_q;
    assign o_fifo_full         = full_q;
    assign o_error             = error_q;

endmodule

// File: tb/tb_gpu_cmd_assembler.sv
// Testbench for gpu_cmd_assembler.
// dut_a: DEPTH 4, MIN_GAP 1, TIMEOUT 16 (latency, timeout, filter, random traffic).
// dut_b: DEPTH 4, MIN_GAP 1000 (backpressure, issue spacing, reset with full FIFO).
// Both share the byte bus and reset; each has its own valid line.
module tb_gpu_cmd_assembler;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b1;
    logic [7:0]  byte_in = 8'h00;
    logic        valid_a = 1'b0;
    logic        valid_b = 1'b0;

    logic        ready_a, rdy_a, full_a, err_a;
    logic [31:0] instr_a;
    logic        ready_b, rdy_b, full_b, err_b;
    logic [31:0] instr_b;

    int          cyc     = 0;
    int          n_checks = 0;
    int          n_fail   = 0;

    // Observation records filled by the monitor below
    logic [31:0] got_a[$];
    int          got_a_cyc[$];
    logic [31:0] got_b[$];
    int          got_b_cyc[$];
    int          err_a_cyc[$];
    int          err_a_n  = 0;
    int          err_b_n  = 0;
    int          zero_a   = 0;
    int          zero_b   = 0;
    int          consec_a = 0;
    int          consec_b = 0;
    logic        prev_a   = 1'b0;
    logic        prev_b   = 1'b0;

    gpu_cmd_assembler #(.DEPTH(4), .MIN_GAP(1), .TIMEOUT(16)) dut_a (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .i_byte              (byte_in),
        .i_byte_valid        (valid_a),
        .o_byte_ready        (ready_a),
        .o_instruction       (instr_a),
        .o_instruction_ready (rdy_a),
        .o_fifo_full         (full_a),
        .o_error             (err_a)
    );

    gpu_cmd_assembler #(.DEPTH(4), .MIN_GAP(1000), .TIMEOUT(4096)) dut_b (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .i_byte              (byte_in),
        .i_byte_valid        (valid_b),
        .o_byte_ready        (ready_b),
        .o_instruction       (instr_b),
        .o_instruction_ready (rdy_b),
        .o_fifo_full         (full_b),
        .o_error             (err_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: record strobes/errors and count protocol violations, on the falling edge
    always @(negedge clk) begin
        if (rdy_a) begin
            got_a.push_back(instr_a);
            got_a_cyc.push_back(cyc);
            if (prev_a) consec_a++;
        end else if (instr_a !== 32'h0) begin
            zero_a++;
        end
        prev_a = rdy_a;
        if (err_a) begin
            err_a_n++;
            err_a_cyc.push_back(cyc);
        end
        if (rdy_b) begin
            got_b.push_back(instr_b);
            got_b_cyc.push_back(cyc);
            if (prev_b) consec_b++;
        end else if (instr_b !== 32'h0) begin
            zero_b++;
        end
        prev_b = rdy_b;
        if (err_b) err_b_n++;
    end

    // Reference rule: which completed words reach the FIFO
    function automatic bit model_accepts(input logic [7:0] op);
`ifdef GPU_CMD_OPCODE_FILTER_EN
        return (op != 8'h00) && (op <= 8'h07);
`else
        return 1'b1;
`endif
    endfunction

    // Present one byte from the falling edge until it is accepted; k = cycle of the accepting edge minus 1
    task automatic send_byte(input bit to_b, input logic [7:0] b, output int k);
        int n;
        @(negedge clk);
        byte_in = b;
        valid_a = !to_b;
        valid_b = to_b;
        n = 0;
        while (((to_b ? ready_b : ready_a) == 1'b0) && n < 1200) begin
            @(negedge clk);
            n++;
        end
        if ((to_b ? ready_b : ready_a) == 1'b0) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_byte: byte_ready got 0 want 1 within 1200 cycles");
        end
        k = cyc;
    endtask

    task automatic send_word(input bit to_b, input logic [31:0] w, output int k);
        for (int i = 0; i < 4; i++) send_byte(to_b, w[8*i +: 8], k);
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        valid_a = 1'b0;
        valid_b = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #10;
        n_checks++; if (instr_a !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 00000000", instr_a); end
        n_checks++; if (rdy_a !== 1'b0) begin n_fail++; $display("FAIL reset_rdy: got %b want 0", rdy_a); end
        n_checks++; if (full_a !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full_a); end
        n_checks++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_a); end
        n_checks++; if (full_b !== 1'b0) begin n_fail++; $display("FAIL reset_full_b: got %b want 0", full_b); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (ready_a !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready_a); end
        n_checks++; if (ready_b !== 1'b1) begin n_fail++; $display("FAIL reset_ready_b: got %b want 1", ready_b); end
    endtask

    task automatic test_single_word();
        int base = got_a.size();
        int e0 = err_a_n;
        int z0 = zero_a;
        int k;
        send_byte(0, 8'h01, k);
        send_byte(0, 8'h0F, k);
        send_byte(0, 8'h0F, k);
        send_byte(0, 8'h00, k);
        idle_cycle();
        wait_cycles(8);
        n_checks++; if (got_a.size() - base != 1) begin n_fail++; $display("FAIL single_count: got %0d pulses want 1", got_a.size() - base); end
        if (got_a.size() > base) begin
            n_checks++; if (got_a[base] !== 32'h000F0F01) begin n_fail++; $display("FAIL single_value: got %h want 000f0f01", got_a[base]); end
            n_checks++; if (got_a_cyc[base] != k + 2) begin n_fail++; $display("FAIL single_latency: got cycle %0d want %0d", got_a_cyc[base], k + 2); end
        end
        n_checks++; if (zero_a != z0) begin n_fail++; $display("FAIL single_idle_zero: got %0d nonzero idle cycles want 0", zero_a - z0); end
        n_checks++; if (err_a_n != e0) begin n_fail++; $display("FAIL single_err: got %0d errors want 0", err_a_n - e0); end
    endtask

    task automatic test_back_to_back();
        int base = got_a.size();
        int c0 = consec_a;
        int k[3];
        for (int w = 0; w < 3; w++) send_word(0, 32'h00000002, k[w]);
        idle_cycle();
        wait_cycles(8);
        n_checks++; if (got_a.size() - base != 3) begin n_fail++; $display("FAIL b2b_count: got %0d pulses want 3", got_a.size() - base); end
        for (int w = 0; w < 3; w++) begin
            if (got_a.size() > base + w) begin
                n_checks++; if (got_a[base + w] !== 32'h00000002) begin n_fail++; $display("FAIL b2b_value[%0d]: got %h want 00000002", w, got_a[base + w]); end
                n_checks++; if (got_a_cyc[base + w] != k[w] + 2) begin n_fail++; $display("FAIL b2b_time[%0d]: got cycle %0d want %0d", w, got_a_cyc[base + w], k[w] + 2); end
            end
        end
        n_checks++; if (consec_a != c0) begin n_fail++; $display("FAIL b2b_strobe_width: got %0d adjacent strobes want 0", consec_a - c0); end
    endtask

    task automatic test_timeout();
        int base = got_a.size();
        int e0 = err_a_n;
        int k;
        int k2;
        // Partial word left idle: discarded with one error pulse
        send_byte(0, 8'h07, k);
        send_byte(0, 8'hAA, k);
        idle_cycle();
        wait_cycles(25);
        n_checks++; if (err_a_n - e0 != 1) begin n_fail++; $display("FAIL timeout_err_count: got %0d want 1", err_a_n - e0); end
        if (err_a_n - e0 == 1) begin
            n_checks++;
            if (err_a_cyc[err_a_cyc.size() - 1] < k + 17 || err_a_cyc[err_a_cyc.size() - 1] > k + 18) begin
                n_fail++; $display("FAIL timeout_err_time: got cycle %0d want %0d..%0d", err_a_cyc[err_a_cyc.size() - 1], k + 17, k + 18);
            end
        end
        n_checks++; if (got_a.size() != base) begin n_fail++; $display("FAIL timeout_no_issue: got %0d pulses want 0", got_a.size() - base); end
        // Fresh word after the discard must be aligned
        send_word(0, 32'h00000005, k);
        idle_cycle();
        wait_cycles(6);
        n_checks++; if (got_a.size() - base != 1) begin n_fail++; $display("FAIL timeout_recover_count: got %0d want 1", got_a.size() - base); end
        if (got_a.size() > base) begin
            n_checks++; if (got_a[base] !== 32'h00000005) begin n_fail++; $display("FAIL timeout_recover_value: got %h want 00000005", got_a[base]); end
        end
        // Bytes arriving exactly on the last counted cycle keep the word alive
        base = got_a.size();
        e0 = err_a_n;
        send_byte(0, 8'h06, k2);
        for (int i = 1; i < 4; i++) begin
            idle_cycle();
            while (cyc < k2 + 15) @(negedge clk);
            send_byte(0, 8'h10 * i[7:0], k2);
        end
        idle_cycle();
        wait_cycles(6);
        n_checks++; if (err_a_n != e0) begin n_fail++; $display("FAIL timeout_edge_err: got %0d errors want 0", err_a_n - e0); end
        n_checks++; if (got_a.size() - base != 1) begin n_fail++; $display("FAIL timeout_edge_count: got %0d want 1", got_a.size() - base); end
        if (got_a.size() > base) begin
            n_checks++; if (got_a[base] !== 32'h30201006) begin n_fail++; $display("FAIL timeout_edge_value: got %h want 30201006", got_a[base]); end
        end
    endtask

    task automatic test_filter();
        int base = got_a.size();
        int e0 = err_a_n;
        int k;
        send_word(0, 32'h03020109, k);
        idle_cycle();
        wait_cycles(6);
`ifdef GPU_CMD_OPCODE_FILTER_EN
        n_checks++; if (err_a_n - e0 != 1) begin n_fail++; $display("FAIL filter_err: got %0d want 1", err_a_n - e0); end
        n_checks++; if (got_a.size() != base) begin n_fail++; $display("FAIL filter_drop: got %0d pulses want 0", got_a.size() - base); end
`else
        n_checks++; if (err_a_n != e0) begin n_fail++; $display("FAIL filter_err: got %0d want 0", err_a_n - e0); end
        n_checks++; if (got_a.size() - base != 1) begin n_fail++; $display("FAIL filter_pass_count: got %0d want 1", got_a.size() - base); end
        if (got_a.size() > base) begin
            n_checks++; if (got_a[base] !== 32'h03020109) begin n_fail++; $display("FAIL filter_pass_value: got %h want 03020109", got_a[base]); end
        end
`endif
    endtask

    task automatic test_random();
        logic [31:0] exp_q[$];
        int exp_err = 0;
        int base = got_a.size();
        int e0 = err_a_n;
        int z0 = zero_a;
        int c0 = consec_a;
        int k;
        logic [31:0] w;
        for (int n = 0; n < 30; n++) begin
            w = {$urandom_range(0, 255) == 0 ? 8'h00 : 8'($urandom), 16'($urandom), 8'($urandom_range(0, 10))};
            if (model_accepts(w[7:0])) exp_q.push_back(w);
            else exp_err++;
            for (int i = 0; i < 4; i++) begin
                send_byte(0, w[8*i +: 8], k);
                repeat ($urandom_range(0, 2)) idle_cycle();
            end
        end
        idle_cycle();
        wait_cycles(10);
        n_checks++; if (got_a.size() - base != exp_q.size()) begin n_fail++; $display("FAIL random_count: got %0d want %0d", got_a.size() - base, exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (got_a.size() > base + i) begin
                n_checks++; if (got_a[base + i] !== exp_q[i]) begin n_fail++; $display("FAIL random_value[%0d]: got %h want %h", i, got_a[base + i], exp_q[i]); end
            end
        end
        n_checks++; if (err_a_n - e0 != exp_err) begin n_fail++; $display("FAIL random_err: got %0d want %0d", err_a_n - e0, exp_err); end
        n_checks++; if (zero_a != z0) begin n_fail++; $display("FAIL random_idle_zero: got %0d want 0", zero_a - z0); end
        n_checks++; if (consec_a != c0) begin n_fail++; $display("FAIL random_strobe_width: got %0d want 0", consec_a - c0); end
    endtask

    task automatic test_backpressure();
        logic [31:0] w[6];
        int base = got_b.size();
        int c0 = consec_b;
        int k;
        int n;
        int r;
        for (int i = 0; i < 6; i++) w[i] = {8'($urandom), 16'($urandom), 8'($urandom_range(1, 7))};
        for (int i = 0; i < 5; i++) begin
            send_word(1, w[i], k);
            idle_cycle();
            if (i == 3) begin
                n_checks++; if (full_b !== 1'b0) begin n_fail++; $display("FAIL bp_full_at3: got %b want 0", full_b); end
            end
        end
        n_checks++; if (full_b !== 1'b1) begin n_fail++; $display("FAIL bp_full_at4: got %b want 1", full_b); end
        n_checks++; if (ready_b !== 1'b1) begin n_fail++; $display("FAIL bp_ready_lane0: got %b want 1", ready_b); end
        for (int i = 0; i < 3; i++) send_byte(1, w[5][8*i +: 8], k);
        @(negedge clk);
        byte_in = w[5][31:24];
        valid_b = 1'b1;
        n_checks++; if (ready_b !== 1'b0) begin n_fail++; $display("FAIL bp_ready_drop: got %b want 0", ready_b); end
        n = 0;
        while (!ready_b && n < 1200) begin @(negedge clk); n++; end
        r = cyc;
        n_checks++; if (!ready_b) begin n_fail++; $display("FAIL bp_ready_rise: got 0 want 1 within 1200 cycles"); end
        idle_cycle();
        n = 0;
        while (got_b.size() - base < 6 && n < 6000) begin @(posedge clk); n++; end
        #1;
        n_checks++; if (got_b.size() - base != 6) begin n_fail++; $display("FAIL bp_count: got %0d want 6", got_b.size() - base); end
        for (int i = 0; i < 6; i++) begin
            if (got_b.size() > base + i) begin
                n_checks++; if (got_b[base + i] !== w[i]) begin n_fail++; $display("FAIL bp_value[%0d]: got %h want %h", i, got_b[base + i], w[i]); end
                if (i > 0) begin
                    n_checks++; if (got_b_cyc[base + i] - got_b_cyc[base + i - 1] != 1001) begin n_fail++; $display("FAIL bp_spacing[%0d]: got %0d want 1001", i, got_b_cyc[base + i] - got_b_cyc[base + i - 1]); end
                end
            end
        end
        if (got_b.size() > base + 1) begin
            n_checks++; if (r != got_b_cyc[base + 1]) begin n_fail++; $display("FAIL bp_ready_time: got cycle %0d want %0d", r, got_b_cyc[base + 1]); end
        end
        n_checks++; if (full_b !== 1'b0) begin n_fail++; $display("FAIL bp_full_end: got %b want 0", full_b); end
        n_checks++; if (consec_b != c0) begin n_fail++; $display("FAIL bp_strobe_width: got %0d want 0", consec_b - c0); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] y = 32'hC0FFEE03;
        logic [31:0] z = 32'h12345604;
        int base_a;
        int base_b;
        int e0;
        int k;
        int n;
        // dut_b sits in its long gap, so these words stay queued
        for (int i = 0; i < 4; i++) send_word(1, 32'h0A0B0C01 + i, k);
        send_byte(1, 8'h55, k);
        send_byte(1, 8'h66, k);
        idle_cycle();
        n_checks++; if (full_b !== 1'b1) begin n_fail++; $display("FAIL mid_prefull: got %b want 1", full_b); end
        send_word(0, 32'h00000007, k);
        idle_cycle();
        n = 0;
        while (!rdy_a && n < 20) begin @(negedge clk); n++; end
        n_checks++; if (rdy_a !== 1'b1) begin n_fail++; $display("FAIL mid_pre_strobe: got %b want 1", rdy_a); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (rdy_a !== 1'b0) begin n_fail++; $display("FAIL mid_rdy: got %b want 0", rdy_a); end
        n_checks++; if (instr_a !== 32'h0) begin n_fail++; $display("FAIL mid_instr: got %h want 00000000", instr_a); end
        n_checks++; if (full_b !== 1'b0) begin n_fail++; $display("FAIL mid_full: got %b want 0", full_b); end
        n_checks++; if (ready_b !== 1'b1) begin n_fail++; $display("FAIL mid_ready_b: got %b want 1", ready_b); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        base_a = got_a.size();
        base_b = got_b.size();
        e0 = err_a_n + err_b_n;
        send_word(1, y, k);
        send_word(0, z, k);
        idle_cycle();
        wait_cycles(10);
        n_checks++; if (got_b.size() - base_b != 1) begin n_fail++; $display("FAIL mid_b_count: got %0d want 1", got_b.size() - base_b); end
        if (got_b.size() > base_b) begin
            n_checks++; if (got_b[base_b] !== y) begin n_fail++; $display("FAIL mid_b_value: got %h want %h", got_b[base_b], y); end
        end
        n_checks++; if (got_a.size() - base_a != 1) begin n_fail++; $display("FAIL mid_a_count: got %0d want 1", got_a.size() - base_a); end
        if (got_a.size() > base_a) begin
            n_checks++; if (got_a[base_a] !== z) begin n_fail++; $display("FAIL mid_a_value: got %h want %h", got_a[base_a], z); end
        end
        n_checks++; if (err_a_n + err_b_n != e0) begin n_fail++; $display("FAIL mid_err: got %0d want 0", err_a_n + err_b_n - e0); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_timeout();
        test_filter();
        test_random();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
